// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler
// Arbitrates the register file's single write port between the pipeline
// writeback stage (always wins) and queued multiply/divide results, which
// drain into idle write slots. Tracks queued destinations for the hazard
// unit and requests a writeback bubble on starvation or a full queue.
module wb_port_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_W,
    input  logic [ADDR_WIDTH-1:0] Rd_W,
    input  logic [DATA_WIDTH-1:0] Result_W,
    input  logic                  MD_Valid,
    input  logic [ADDR_WIDTH-1:0] MD_Rd,
    input  logic [DATA_WIDTH-1:0] MD_Result,
    output logic                  MD_Ready,
    input  logic [ADDR_WIDTH-1:0] Rs1_D,
    input  logic [ADDR_WIDTH-1:0] Rs2_D,
    output logic                  Pending_Hit,
    output logic                  Stall_Req,
    output logic                  RF_WE,
    output logic [ADDR_WIDTH-1:0] RF_A3,
    output logic [DATA_WIDTH-1:0] RF_WD
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // Queue storage; entry payload carries no reset, the valid bits gate it.
    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    // Control state.
    logic [DEPTH-1:0]  vld_q,    vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [WAIT_W-1:0] wait_q,   wait_d;
    logic              stall_q,  stall_d;

    // Per-cycle decisions.
    logic pw;
    logic nonempty;
    logic ready;
    logic acc;
    logic push;
    logic pop;
    logic head_vld;
    logic hit;

    // Circular pointer advance, wrapping DEPTH-1 -> 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Wait counter advance, holding at MAX_WAIT.
    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] w);
        return (w >= MAX_WAIT_C) ? w : w + WAIT_W'(1);
    endfunction

    assign pw       = RegWrite_W && (Rd_W != '0);
    assign nonempty = (count_q != '0);
    // Readiness looks only at the registered count: a drain this cycle
    // frees a slot for the next cycle, not this one.
    assign ready    = !rst && (count_q < DEPTH_C);
    assign acc      = MD_Valid && ready;
    // x0 results are acknowledged but dropped.
    assign push     = acc && (MD_Rd != '0);
    // The head leaves whenever the pipeline leaves the port idle; a killed
    // head leaves too, just without a write.
    assign pop      = !rst && !pw && nonempty;
    assign head_vld = vld_q[rd_ptr_q];

    assign MD_Ready  = ready;
    assign Stall_Req = stall_q;

    // Write-port mux: pipeline first, then a live queue head, else idle.
    always_comb begin
        RF_WE = 1'b0;
        RF_A3 = '0;
        RF_WD = '0;
        if (!rst) begin
            if (pw) begin
                RF_WE = 1'b1;
                RF_A3 = Rd_W;
                RF_WD = Result_W;
            end else if (nonempty && head_vld) begin
                RF_WE = 1'b1;
                RF_A3 = rd_q[rd_ptr_q];
                RF_WD = data_q[rd_ptr_q];
            end
        end
    end

    // Source match against live queued destinations (not this cycle's accept).
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_q[i] != '0) &&
                ((rd_q[i] == Rs1_D) || (rd_q[i] == Rs2_D))) begin
                hit = 1'b1;
            end
        end
        Pending_Hit = hit && !rst;
    end

    // Next-state for queue control, wait counter and stall request.
    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;

        // A younger pipeline write to the same register makes queued data stale.
        if (pw) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && (rd_q[i] == Rd_W)) begin
                    vld_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = ptr_inc(rd_ptr_q);
        end

        // Push lands in a slot distinct from a popping head: a push with a
        // pop requires count < DEPTH and count > 0.
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Only a pipeline write can block a non-empty queue; otherwise it pops.
        if (!nonempty || !pw) begin
            wait_d = '0;
        end else begin
            wait_d = wait_inc(wait_q);
        end

        stall_d = (wait_d >= MAX_WAIT_C) || (count_d == DEPTH_C);
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
            stall_q  <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
        end
    end

    // Entry payload capture on accept.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= MD_Rd;
            data_q[wr_ptr_q] <= MD_Result;
        end
    end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler (DATA_WIDTH=32, ADDR_WIDTH=5,
// DEPTH=2, MAX_WAIT=4). Inputs change on the falling edge; outputs are
// sampled 1 ns later, well before the next rising edge.
module tb_wb_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        rw;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        mdv;
    logic [4:0]  mdrd;
    logic [31:0] mdres;
    logic        md_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        phit;
    logic        stall;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;

    int checks = 0;
    int passes = 0;

    wb_port_scheduler #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .DEPTH(2),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite_W (rw),
        .Rd_W       (rdw),
        .Result_W   (resw),
        .MD_Valid   (mdv),
        .MD_Rd      (mdrd),
        .MD_Result  (mdres),
        .MD_Ready   (md_ready),
        .Rs1_D      (rs1),
        .Rs2_D      (rs2),
        .Pending_Hit(phit),
        .Stall_Req  (stall),
        .RF_WE      (we),
        .RF_A3      (a3),
        .RF_WD      (wd)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Start a new cycle with every input idle.
    task automatic idle_cycle();
        @(negedge clk);
        rst = 1'b0; rw = 1'b0; rdw = '0; resw = '0;
        mdv = 1'b0; mdrd = '0; mdres = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic test_reset();
        idle_cycle();
        rst = 1'b1; rw = 1'b1; rdw = 5'd5; resw = 32'h1234; mdv = 1'b1; mdrd = 5'd3; rs1 = 5'd3;
        #1;
        checks++; if (we !== 1'b0) $display("FAIL rst_we: got %0h want 0", we); else passes++;
        checks++; if (md_ready !== 1'b0) $display("FAIL rst_ready: got %0h want 0", md_ready); else passes++;
        checks++; if (phit !== 1'b0) $display("FAIL rst_phit: got %0h want 0", phit); else passes++;
        idle_cycle(); #1;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0h want 0", stall); else passes++;
        checks++; if (we !== 1'b0) $display("FAIL rst_idle_we: got %0h want 0", we); else passes++;
        checks++; if (md_ready !== 1'b1) $display("FAIL rst_idle_ready: got %0h want 1", md_ready); else passes++;
    endtask

    task automatic test_pipeline_only();
        idle_cycle();
        rw = 1'b1; rdw = 5'd5; resw = 32'hDEADBEEF; #1;
        checks++; if (we !== 1'b1) $display("FAIL pipe_we: got %0h want 1", we); else passes++;
        checks++; if (a3 !== 5'd5) $display("FAIL pipe_a3: got %0d want 5", a3); else passes++;
        checks++; if (wd !== 32'hDEADBEEF) $display("FAIL pipe_wd: got %0h want deadbeef", wd); else passes++;
        checks++; if (md_ready !== 1'b1) $display("FAIL pipe_ready: got %0h want 1", md_ready); else passes++;
        idle_cycle();
        rw = 1'b1; rdw = 5'd0; resw = 32'h77; #1;
        checks++; if (we !== 1'b0) $display("FAIL pipe_x0_we: got %0h want 0", we); else passes++;
        idle_cycle(); #1;
        checks++; if (we !== 1'b0) $display("FAIL pipe_after_we: got %0h want 0", we); else passes++;
    endtask

    task automatic test_md_idle();
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd7; mdres = 32'd42; rs1 = 5'd7; #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL md_ready: got %0h want 1", md_ready); else passes++;
        checks++; if (we !== 1'b0) $display("FAIL md_nobypass_we: got %0h want 0", we); else passes++;
        checks++; if (phit !== 1'b0) $display("FAIL md_accept_phit: got %0h want 0", phit); else passes++;
        idle_cycle();
        rs1 = 5'd7; #1;
        checks++; if (we !== 1'b1) $display("FAIL md_we: got %0h want 1", we); else passes++;
        checks++; if (a3 !== 5'd7) $display("FAIL md_a3: got %0d want 7", a3); else passes++;
        checks++; if (wd !== 32'd42) $display("FAIL md_wd: got %0d want 42", wd); else passes++;
        checks++; if (phit !== 1'b1) $display("FAIL md_phit: got %0h want 1", phit); else passes++;
        idle_cycle();
        rs2 = 5'd7; #1;
        checks++; if (phit !== 1'b0) $display("FAIL md_phit_after: got %0h want 0", phit); else passes++;
        checks++; if (we !== 1'b0) $display("FAIL md_we_after: got %0h want 0", we); else passes++;
    endtask

    task automatic test_starvation();
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd6; mdres = 32'd66; #1;
        for (int c = 1; c <= 4; c++) begin
            idle_cycle();
            rw = 1'b1; rdw = 5'd3; resw = 32'd33; #1;
            checks++; if (a3 !== 5'd3) $display("FAIL starve_a3_c%0d: got %0d want 3", c, a3); else passes++;
            checks++; if (stall !== 1'b0) $display("FAIL starve_stall_c%0d: got %0h want 0", c, stall); else passes++;
        end
        idle_cycle(); #1;
        checks++; if (stall !== 1'b1) $display("FAIL starve_stall_c5: got %0h want 1", stall); else passes++;
        checks++; if (we !== 1'b1 || a3 !== 5'd6 || wd !== 32'd66)
            $display("FAIL starve_drain: got we=%0h a3=%0d wd=%0d want we=1 a3=6 wd=66", we, a3, wd); else passes++;
        idle_cycle(); #1;
        checks++; if (stall !== 1'b0) $display("FAIL starve_stall_c6: got %0h want 0", stall); else passes++;
        checks++; if (we !== 1'b0) $display("FAIL starve_we_c6: got %0h want 0", we); else passes++;
    endtask

    task automatic test_full_wrap();
        idle_cycle();
        rw = 1'b1; rdw = 5'd10; resw = 32'h10; mdv = 1'b1; mdrd = 5'd1; mdres = 32'd1; #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL full_ready_c0: got %0h want 1", md_ready); else passes++;
        idle_cycle();
        rw = 1'b1; rdw = 5'd11; resw = 32'h11; mdv = 1'b1; mdrd = 5'd2; mdres = 32'd2; #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL full_ready_c1: got %0h want 1", md_ready); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL full_stall_c1: got %0h want 0", stall); else passes++;
        idle_cycle();
        rw = 1'b1; rdw = 5'd12; resw = 32'h12; mdv = 1'b1; mdrd = 5'd4; mdres = 32'd4; #1;
        checks++; if (md_ready !== 1'b0) $display("FAIL full_ready_c2: got %0h want 0", md_ready); else passes++;
        checks++; if (stall !== 1'b1) $display("FAIL full_stall_c2: got %0h want 1", stall); else passes++;
        checks++; if (a3 !== 5'd12) $display("FAIL full_pipe_a3: got %0d want 12", a3); else passes++;
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd4; mdres = 32'd4; #1;
        checks++; if (md_ready !== 1'b0) $display("FAIL full_ready_drain: got %0h want 0", md_ready); else passes++;
        checks++; if (we !== 1'b1 || a3 !== 5'd1 || wd !== 32'd1)
            $display("FAIL full_drain1: got we=%0h a3=%0d wd=%0d want we=1 a3=1 wd=1", we, a3, wd); else passes++;
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd4; mdres = 32'd4; #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL full_ready_c4: got %0h want 1", md_ready); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL full_stall_c4: got %0h want 0", stall); else passes++;
        checks++; if (we !== 1'b1 || a3 !== 5'd2 || wd !== 32'd2)
            $display("FAIL full_drain2: got we=%0h a3=%0d wd=%0d want we=1 a3=2 wd=2", we, a3, wd); else passes++;
        idle_cycle(); #1;
        checks++; if (we !== 1'b1 || a3 !== 5'd4 || wd !== 32'd4)
            $display("FAIL full_wrap: got we=%0h a3=%0d wd=%0d want we=1 a3=4 wd=4", we, a3, wd); else passes++;
        idle_cycle(); #1;
        checks++; if (we !== 1'b0) $display("FAIL full_empty_we: got %0h want 0", we); else passes++;
    endtask

    task automatic test_kill();
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd9; mdres = 32'd100; #1;
        idle_cycle();
        rw = 1'b1; rdw = 5'd9; resw = 32'd200; rs1 = 5'd9; #1;
        checks++; if (we !== 1'b1 || a3 !== 5'd9 || wd !== 32'd200)
            $display("FAIL kill_pipe: got we=%0h a3=%0d wd=%0d want we=1 a3=9 wd=200", we, a3, wd); else passes++;
        checks++; if (phit !== 1'b1) $display("FAIL kill_phit_before: got %0h want 1", phit); else passes++;
        idle_cycle();
        rs1 = 5'd9; #1;
        checks++; if (we !== 1'b0) $display("FAIL kill_pop_we: got %0h want 0", we); else passes++;
        checks++; if (phit !== 1'b0) $display("FAIL kill_phit_after: got %0h want 0", phit); else passes++;
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd13; mdres = 32'd13; #1;
        checks++; if (we !== 1'b0) $display("FAIL kill_no_stale_we: got %0h want 0", we); else passes++;
        idle_cycle(); #1;
        checks++; if (we !== 1'b1 || a3 !== 5'd13 || wd !== 32'd13)
            $display("FAIL kill_next_drain: got we=%0h a3=%0d wd=%0d want we=1 a3=13 wd=13", we, a3, wd); else passes++;
    endtask

    task automatic test_zero_rd();
        idle_cycle();
        mdv = 1'b1; mdrd = 5'd0; mdres = 32'd55; #1;
        checks++; if (md_ready !== 1'b1) $display("FAIL x0_ready: got %0h want 1", md_ready); else passes++;
        idle_cycle(); #1;
        checks++; if (we !== 1'b0 || wd !== 32'd0)
            $display("FAIL x0_not_queued: got we=%0h wd=%0d want we=0 wd=0", we, wd); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL x0_stall: got %0h want 0", stall); else passes++;
    endtask

    task automatic test_reset_mid();
        idle_cycle();
        rw = 1'b1; rdw = 5'd20; resw = 32'd20; mdv = 1'b1; mdrd = 5'd21; mdres = 32'd21; #1;
        idle_cycle();
        rw = 1'b1; rdw = 5'd22; resw = 32'd22; mdv = 1'b1; mdrd = 5'd23; mdres = 32'd23; #1;
        idle_cycle();
        rst = 1'b1; rs1 = 5'd21; rs2 = 5'd23; #1;
        checks++; if (stall !== 1'b1) $display("FAIL mid_stall_full: got %0h want 1", stall); else passes++;
        checks++; if (we !== 1'b0) $display("FAIL mid_rst_we: got %0h want 0", we); else passes++;
        checks++; if (phit !== 1'b0) $display("FAIL mid_rst_phit: got %0h want 0", phit); else passes++;
        idle_cycle();
        rs1 = 5'd21; rs2 = 5'd23; #1;
        checks++; if (we !== 1'b0) $display("FAIL mid_after_we: got %0h want 0", we); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL mid_after_stall: got %0h want 0", stall); else passes++;
        checks++; if (phit !== 1'b0) $display("FAIL mid_after_phit: got %0h want 0", phit); else passes++;
        checks++; if (md_ready !== 1'b1) $display("FAIL mid_after_ready: got %0h want 1", md_ready); else passes++;
        idle_cycle(); #1;
        checks++; if (we !== 1'b0) $display("FAIL mid_after2_we: got %0h want 0", we); else passes++;
    endtask

    initial begin
        rst = 1'b1; rw = 1'b0; rdw = '0; resw = '0;
        mdv = 1'b0; mdrd = '0; mdres = '0; rs1 = '0; rs2 = '0;
        test_reset();
        test_pipeline_only();
        test_md_idle();
        test_starvation();
        test_full_wrap();
        test_kill();
        test_zero_rd();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_scheduler.md
# wb_port_scheduler

Shares the register file's single write port between the pipeline's writeback stage and the multi-cycle multiply/divide unit. Pipeline writeback (the selected `Result_W`) always owns the port in the cycle it is presented. Multiply/divide results are queued in a small FIFO and drained into idle write-port slots. The block also reports registers with queued results to the hazard unit, and requests a writeback bubble when a queued result has starved or the queue is full.

## Interface
Parameters
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register index width
- `DEPTH`, 2, mul/div result FIFO entries (≥1)
- `MAX_WAIT`, 4, consecutive blocked cycles before the stall request (≥1)

Ports

One clock; reset is synchronous and active-high.

- `clk` in 1: clock, all state updates on the rising edge
- `rst` in 1: synchronous active-high reset
- `RegWrite_W` in 1: pipeline writeback enable
- `Rd_W` in ADDR_WIDTH: pipeline destination register
- `Result_W` in DATA_WIDTH: pipeline writeback data
- `MD_Valid` in 1: mul/div result valid
- `MD_Rd` in ADDR_WIDTH: mul/div destination register
- `MD_Result` in DATA_WIDTH: mul/div result data
- `MD_Ready` out 1: scheduler accepts the mul/div result this cycle
- `Rs1_D`, `Rs2_D` in ADDR_WIDTH: decode-stage source registers
- `Pending_Hit` out 1: either source matches a queued entry
- `Stall_Req` out 1: request to the hazard unit for a writeback bubble
- `RF_WE` out 1: register-file write enable
- `RF_A3` out ADDR_WIDTH: register-file write address
- `RF_WD` out DATA_WIDTH: register-file write data

## Operation
- **Pipeline write:** `pw = RegWrite_W && Rd_W != 0`.
- **Port selection (combinational):**
  - If `pw`: `RF_WE=1`, `RF_A3=Rd_W`, `RF_WD=Result_W`.
  - Else if the FIFO is non-empty: write the head entry with `RF_WE=1`. That is a drain.
  - Else `RF_WE=0`, with `RF_A3` and `RF_WD` at 0.
- **Accept:** `acc = MD_Valid && MD_Ready`.
  - `MD_Ready = !rst && count < DEPTH`.
  - A drain in the same cycle does not raise `MD_Ready`.
  - An accepted result with `MD_Rd == 0` is discarded and not queued.
- **No bypass:** an accepted entry is written to the register file no earlier than the next cycle.
- **FIFO:**
  - Circular buffer with read and write pointers modulo `DEPTH` and a count in `0..DEPTH`.
  - Accept and drain in the same cycle leave `count` unchanged.
  - Pointers wrap from `DEPTH-1` to 0.
- **Kill:** when `pw` and a valid queued entry has `rd == Rd_W`, that entry is invalidated, because the pipeline write is younger.
  - A killed entry still occupies its slot.
  - When a killed entry reaches the head, it is popped with `RF_WE=0` for that slot.
  - The pop happens in any cycle without `pw`.
- **Pending_Hit:** combinational.
  - High when any valid, unkilled entry has `rd != 0` and `rd` equal to `Rs1_D` or `Rs2_D`.
  - An entry being accepted this cycle is not included.
- **Wait counter:**
  - Increments each cycle the FIFO is non-empty and `pw` blocks the drain, saturating at `MAX_WAIT`.
  - Clears on any pop, and when the FIFO is empty.
- **Stall_Req (registered):** next value is `(wait_next >= MAX_WAIT) || (count_next == DEPTH)`.
- **Hazard-unit contract:** while `Stall_Req` is high it inserts bubbles (`RegWrite_W=0`). If it does not, the pipeline still wins the port and nothing is corrupted.

## Timing
- **Reset** (the cycle `rst` is high, then the next edge):
  - `count`, pointers, valid bits, wait counter and `Stall_Req` all go to 0.
  - During reset, `RF_WE`, `MD_Ready` and `Pending_Hit` are forced to 0.
  - Reset mid-operation discards all queued results without writing them.
- **Pipeline write latency:** 0 cycles, combinational pass-through written at the same edge.
- **Mul/div latency:** minimum 1 cycle from accept to register-file write.
- **Empty and full:**
  - Empty: no drain.
  - Full (`count == DEPTH`): `MD_Ready=0`, and the mul/div unit must hold `MD_Valid`, `MD_Rd` and `MD_Result` stable until accepted.
- **Stall_Req** rises one cycle after the cycle in which the FIFO becomes full, or in which the wait counter reaches `MAX_WAIT`. It falls one cycle after the condition clears.

## Test plan
- Pipeline only: `RegWrite_W=1`, `Rd_W=5`, `Result_W=0xDEADBEEF` → same cycle `RF_WE=1`, `RF_A3=5`, `RF_WD=0xDEADBEEF`. FIFO is untouched and `MD_Ready=1`.
- Mul/div with the port idle: accept `MD_Rd=7`, `MD_Result=42` in cycle N with `RegWrite_W=0` → cycle N+1 `RF_WE=1`, `RF_A3=7`, `RF_WD=42`. `Pending_Hit=1` with `Rs1_D=7` during N+1, and 0 at N+2.
- Starvation (`MAX_WAIT=4`): one queued entry, `RegWrite_W=1` to x3 for 4 cycles → `Stall_Req=1` in cycle 5. Drop `RegWrite_W` → entry drains that cycle and `Stall_Req` returns to 0 the next cycle.
- Full and wrap: accept 2 entries (x1=1, x2=2) under continuous `pw` → `MD_Ready=0` and `Stall_Req=1`. Release → drains in order x1 then x2. Then accept x4=4 → written from slot 0 after the pointer wrap.
- Kill: x9=100 queued, pipeline writes x9=200 → `RF_WD=200`. The next idle slot has `RF_WE=0` as the killed entry pops, and x9 is never written with 100.
- Edge cases:
  - Accept with `MD_Rd=0` → nothing queued and `count` stays 0.
  - Assert `rst` with 2 entries queued → no register-file writes after reset and `count=0`.
